bcd_display_scanner: RTL and testbench
======================================

# bcd_display_scanner

Two-digit multiplexed seven-segment driver that consumes the `tens`/`units` BCD pair produced by the BCD counter and drives a shared segment bus plus per-digit anode selects. It holds a pending/shadow register pair so a new value is committed only at a frame boundary, which prevents digit tearing. It also supports optional leading-zero blanking and flags invalid BCD input. It sits between the counter and the board display pins.

## Interface
- `REFRESH_DIV`, default 4: clock cycles per digit phase; legal range is 2 or more.
- `BLANK_LEADING`, default 1: when 1, the tens digit is blanked while the committed tens value is 0.
- `SEG_ACTIVE_LOW`, default 1: when 1, `seg` is inverted at the output.
- `clk`, input, 1 bit: single clock; everything is rising-edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `load`, input, 1 bit: single-cycle strobe that captures `tens_in`/`units_in` into the pending register.
- `tens_in`, input, 4 bits: BCD tens digit.
- `units_in`, input, 4 bits: BCD units digit.
- `seg`, output, 7 bits: segments `{g,f,e,d,c,b,a}`, registered.
- `an`, output, 2 bits: one-hot digit select, active-high; `an[0]` = units, `an[1]` = tens. Registered.
- `frame_start`, output, 1 bit: one-cycle pulse on the first output cycle of each units phase.
- `err`, output, 1 bit: sticky flag; set when a loaded digit is greater than 9, cleared only by `rst`.

## Operation
- **State:**
  - prescaler `pcnt` counts 0..REFRESH_DIV-1.
  - `phase` is UNITS or TENS.
  - pending register `{p_tens, p_units}` plus `p_valid`.
  - shadow register `{s_tens, s_units}`.
- **Phase FSM:**
  - When `pcnt == REFRESH_DIV-1`: `pcnt` goes to 0 and `phase` toggles (UNITS→TENS→UNITS).
  - Otherwise `pcnt` increments.
  - One frame is 2·REFRESH_DIV cycles.
- **Commit point:** the terminal-count cycle with `phase == TENS`, i.e. the TENS→UNITS transition.
  - If `p_valid`: shadow ← pending, and `p_valid` is cleared.
- **Load rules:**
  - `load` writes the pending register and sets `p_valid`.
  - Back-to-back loads: the last one wins.
  - `load` in the commit cycle: the load data goes straight into the shadow register (bypass), and `p_valid` ends up 0.
- **Digit decode:**
  - Select `s_units` in the UNITS phase and `s_tens` in the TENS phase.
  - Values 0–9 map to the standard patterns (active-high): 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - A value greater than 9 maps to a dash (40).
  - Blank is 00.
- **Blanking:** in the TENS phase with `BLANK_LEADING=1` and `s_tens == 0`, `seg` shows blank. `an` still asserts `2'b10`, so the duty cycle is unchanged.
- **err:** set on the cycle after any `load` where `tens_in > 9` or `units_in > 9`.

## Timing
- **Reset values (asynchronous):**
  - `pcnt = 0`, `phase = UNITS`.
  - pending = 0, `p_valid = 0`, shadow = 0.
  - `an = 2'b00`.
  - `seg` = all segments off (7'h7F if active-low, 7'h00 otherwise).
  - `frame_start = 0`, `err = 0`.
- **Output latency:** `seg`, `an` and `frame_start` are registered from the current `phase`/`pcnt`/shadow state, so they lag the state by one cycle.
  - First rising edge after `rst` deasserts: `an = 01`, `seg` = pattern for "0", `frame_start = 1`.
- **Load-to-display latency:** a `load` is visible from the first UNITS output cycle after the next commit point. Worst case is about 2·REFRESH_DIV + 1 cycles.
- **Reset mid-frame:** all state returns to the reset values immediately. Pending data is discarded.

## Structure
- **Shared package `bcd_disp_pkg`:**
  - segment pattern constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`
  - phase encoding `PH_UNITS`/`PH_TENS`
- **Sub-module `bcd_to_seg`:** combinational 4-bit → 7-bit decoder producing the dash for inputs greater than 9.
- **Top level:** prescaler, phase FSM, pending/shadow registers, blanking mux, polarity inversion and output registers.

## Test plan
All scenarios use REFRESH_DIV=4 (8-cycle frame), BLANK_LEADING=1, SEG_ACTIVE_LOW=0.
1. **Reset and idle:** release `rst` and run 16 cycles.
   - Expect `an` to follow 01×4, 10×4, repeating.
   - Expect `seg = 3F` in units cycles and `00` in tens cycles (leading zero blanked).
   - Expect `frame_start` high every 8 cycles.
2. **Load and commit:** load tens=4, units=7 mid-units-phase.
   - Expect no change until the next frame.
   - Then expect units cycles with `seg = 07` and tens cycles with `seg = 66`.
3. **Back-to-back loads:** load 12, then 35 in the same frame.
   - Expect only 35 to be displayed (`seg` 6D / 4F); 12 never appears.
4. **Load in the commit cycle:** load 9,9 exactly at the TENS terminal count.
   - Expect `seg = 6F` in the immediately following units phase.
5. **Invalid BCD:** load tens=0xA, units=3.
   - Expect `err = 1` on the next cycle.
   - After commit, expect the tens digit to show 40 (dash) and units to show 4F.
   - Expect `err` to stay 1 until `rst`.
6. **Reset mid-operation:** assert `rst` with a pending load and shadow = 58.
   - Expect `an = 00`, `seg = 00` and `err = 0` immediately (asynchronously).
   - After release, expect the display to show 0 and no stale value to appear.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit seven-segment scanner: active-high
// segment patterns ({g,f,e,d,c,b,a}) and the digit-phase encoding.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        PH_UNITS = 1'b0,
        PH_TENS  = 1'b1
    } phase_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-high seven-segment pattern; non-BCD
// codes show a dash so bad input is visible on the display.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed seven-segment driver. New values wait in a pending
// register and reach the displayed (shadow) register only at a frame boundary.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 4,
    parameter bit          BLANK_LEADING  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] tens_in,
    input  logic [3:0] units_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_start,
    output logic       err
);

    localparam int unsigned   PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [PW-1:0] pcnt;
    phase_t        phase;
    logic [3:0]    p_tens, p_units;
    logic          p_valid;
    logic [3:0]    s_tens, s_units;

    logic [3:0] digit;
    logic [6:0] pattern;
    logic [6:0] seg_next;
    logic       terminal;
    logic       commit;

    assign terminal = (pcnt == PCNT_LAST);
    assign commit   = terminal && (phase == PH_TENS);
    assign digit    = (phase == PH_TENS) ? s_tens : s_units;

    bcd_to_seg u_dec (
        .digit   (digit),
        .pattern (pattern)
    );

    always_comb begin
        seg_next = pattern;
        if (BLANK_LEADING && (phase == PH_TENS) && (s_tens == 4'd0))
            seg_next = SEG_BLANK;
        if (SEG_ACTIVE_LOW)
            seg_next = ~seg_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt        <= '0;
            phase       <= PH_UNITS;
            p_tens      <= '0;
            p_units     <= '0;
            p_valid     <= 1'b0;
            s_tens      <= '0;
            s_units     <= '0;
            an          <= 2'b00;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (terminal) begin
                pcnt  <= '0;
                phase <= (phase == PH_UNITS) ? PH_TENS : PH_UNITS;
            end else begin
                pcnt <= pcnt + 1'b1;
            end

            if (load) begin
                p_tens  <= tens_in;
                p_units <= units_in;
            end

            // A load landing on the commit cycle bypasses pending straight to shadow.
            if (commit) begin
                p_valid <= 1'b0;
                if (load) begin
                    s_tens  <= tens_in;
                    s_units <= units_in;
                end else if (p_valid) begin
                    s_tens  <= p_tens;
                    s_units <= p_units;
                end
            end else if (load) begin
                p_valid <= 1'b1;
            end

            if (load && ((tens_in > 4'd9) || (units_in > 4'd9)))
                err <= 1'b1;

            an          <= (phase == PH_UNITS) ? 2'b01 : 2'b10;
            seg         <= seg_next;
            frame_start <= (phase == PH_UNITS) && (pcnt == '0);
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: per-cycle expectations come from a
// frame-level model (display = last value loaded at or before the latest commit).
module tb_bcd_display_scanner;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 2 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] tens_in = 4'd0;
    logic [3:0] units_in = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_start;
    logic       err;

    bcd_display_scanner #(
        .REFRESH_DIV    (DIV),
        .BLANK_LEADING  (1'b1),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .tens_in     (tens_in),
        .units_in    (units_in),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       fs;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // model state: cycle index since reset release, last loaded value,
    // value latched at the most recent frame boundary, sticky error
    int unsigned cyc = 0;
    logic [3:0]  lt = 4'd0, lu = 4'd0, ct = 4'd0, cu = 4'd0;
    logic        m_err = 1'b0;

    function automatic logic [6:0] shown(input logic tens_ph, input logic [3:0] t,
                                         input logic [3:0] u);
        logic [3:0] d;
        d = tens_ph ? t : u;
        if (tens_ph && t == 4'd0) return 7'h00;
        if (d > 4'd9) return 7'h40;
        return pat[d];
    endfunction

    task automatic step(input logic ld, input logic [3:0] t, input logic [3:0] u);
        exp_t        e;
        int unsigned pos;
        logic        tens_ph;
        @(negedge clk);
        load     = ld;
        tens_in  = t;
        units_in = u;
        pos      = cyc % FRAME;
        tens_ph  = (pos >= DIV);
        e.an     = tens_ph ? 2'b10 : 2'b01;
        e.seg    = shown(tens_ph, ct, cu);
        e.fs     = (pos == 0);
        if (ld) begin
            lt = t;
            lu = u;
            if (t > 4'd9 || u > 4'd9) m_err = 1'b1;
        end
        e.err = m_err;
        sb.push_back(e);
        if (pos == FRAME - 1) begin
            ct = lt;
            cu = lu;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0);
    endtask

    task automatic to_pos(input int unsigned p);
        while (cyc % FRAME != p) step(1'b0, 4'd0, 4'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (an !== 2'b00) begin
            fails++;
            $display("FAIL %s_an: got %b expected 00", tag, an);
        end
        checks++;
        if (seg !== 7'h00) begin
            fails++;
            $display("FAIL %s_seg: got %h expected 00", tag, seg);
        end
        checks++;
        if (frame_start !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s_fs_err: got fs=%b err=%b expected 0/0", tag, frame_start, err);
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #3 rst = 1'b0;
        cyc   = 0;
        lt    = 4'd0;
        lu    = 4'd0;
        ct    = 4'd0;
        cu    = 4'd0;
        m_err = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && an != 2'b00) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: an=%b seg=%h with empty scoreboard", an, seg);
            end else begin
                e = sb.pop_front();
                if ({an, seg, frame_start, err} !== e) begin
                    fails++;
                    $display("FAIL display t=%0t: got an=%b seg=%h fs=%b err=%b expected an=%b seg=%h fs=%b err=%b",
                             $time, an, seg, frame_start, err, e.an, e.seg, e.fs, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        release_rst();

        // idle frames: 0 shown, leading zero blanked
        idle(16);

        // load mid-units-phase
        to_pos(1);
        step(1'b1, 4'd4, 4'd7);
        idle(24);

        // back-to-back loads within one frame
        to_pos(0);
        step(1'b1, 4'd1, 4'd2);
        step(1'b0, 4'd0, 4'd0);
        step(1'b1, 4'd3, 4'd5);
        idle(24);

        // load exactly on the commit cycle
        to_pos(FRAME - 1);
        step(1'b1, 4'd9, 4'd9);
        idle(16);

        // invalid BCD tens digit
        to_pos(2);
        step(1'b1, 4'hA, 4'd3);
        idle(24);

        // reset with shadow=58 and a pending 12
        to_pos(0);
        step(1'b1, 4'd5, 4'd8);
        idle(16);
        to_pos(2);
        step(1'b1, 4'd1, 4'd2);
        step(1'b0, 4'd0, 4'd0);
        @(negedge clk);
        load = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        release_rst();
        idle(24);

        // random loads, including commit-cycle and invalid digits
        for (int i = 0; i < 300; i++) begin
            logic       ld;
            logic [3:0] t, u;
            ld = ($urandom % 4 == 0);
            t  = ($urandom % 16 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            u  = ($urandom % 16 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step(ld, t, u);
        end
        step(1'b0, 4'd0, 4'd0);
        @(posedge clk);
        #2;

        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected outputs never observed, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
